// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the delay timer monitor.
package delay_timer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    DELAY     = 2'd2,
    WIDTH     = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX_DEF = '1;

endpackage

// File: rtl/edge_sync.sv
// One-bit input synchroniser with rise/fall detection. MONITOR_SYNC2_EN selects
// a two-flop synchroniser; otherwise a single input flop is used.
module edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic sync_q;
  logic hist_q;

`ifdef MONITOR_SYNC2_EN
  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      sync_q <= d;
      hist_q <= sync_q;
    end
  end
`endif

  assign rise = sync_q & ~hist_q;
  assign fall = ~sync_q & hist_q;

endmodule

// File: rtl/delay_timer_monitor.sv
// Measures trigger-to-output delay and output pulse width of a delay timer.
// Input synchroniser depth is selected by MONITOR_SYNC2_EN (see edge_sync).
module delay_timer_monitor
  import delay_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             i_en,
  input  logic             i_TRIG,
  input  logic             i_delay_n,
  output logic [CNT_W-1:0] o_delay_cnt,
  output logic [CNT_W-1:0] o_width_cnt,
  output logic             o_valid,
  output logic             o_sat,
  output logic             o_abort,
  output logic             o_busy,
  output state_e           o_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic trig_rise, trig_fall;
  logic out_on, out_off;

  edge_sync #(.RST_VAL(1'b0)) u_trig_sync (
    .clk  (clk),
    .rst  (RESET),
    .d    (i_TRIG),
    .rise (trig_rise),
    .fall (trig_fall)
  );

  // i_delay_n is active low: its falling edge is the output asserting.
  edge_sync #(.RST_VAL(1'b1)) u_out_sync (
    .clk  (clk),
    .rst  (RESET),
    .d    (i_delay_n),
    .rise (out_off),
    .fall (out_on)
  );

  state_e           state;
  logic [CNT_W-1:0] dcnt, wcnt, dlat;
  logic [CNT_W-1:0] d_inc, w_inc;
  logic             d_max, w_max;
  logic             sat;

  // A counter already at max that is asked to advance marks the capture saturated.
  always_comb begin
    d_max = (dcnt == CNT_MAX);
    w_max = (wcnt == CNT_MAX);
    d_inc = d_max ? dcnt : dcnt + 1'b1;
    w_inc = w_max ? wcnt : wcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      dcnt        <= '0;
      wcnt        <= '0;
      dlat        <= '0;
      sat         <= 1'b0;
      o_delay_cnt <= '0;
      o_width_cnt <= '0;
      o_valid     <= 1'b0;
      o_sat       <= 1'b0;
      o_abort     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_en) begin
        state  <= IDLE;
        o_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_TRIG;
          WAIT_TRIG: begin
            if (trig_rise) begin
              sat    <= 1'b0;
              dcnt   <= '0;
              o_busy <= 1'b1;
              if (out_on) begin
                state <= WIDTH;
                dlat  <= '0;
                wcnt  <= '0;
              end else begin
                state <= DELAY;
              end
            end
          end
          DELAY: begin
            if (out_on) begin
              state <= WIDTH;
              dlat  <= d_inc;
              wcnt  <= '0;
              sat   <= sat | d_max;
            end else if (trig_fall) begin
              state       <= WAIT_TRIG;
              o_busy      <= 1'b0;
              o_valid     <= 1'b1;
              o_abort     <= 1'b1;
              o_sat       <= sat | d_max;
              o_delay_cnt <= d_inc;
              o_width_cnt <= '0;
            end else begin
              dcnt <= d_inc;
              sat  <= sat | d_max;
            end
          end
          WIDTH: begin
            if (out_off) begin
              state       <= WAIT_TRIG;
              o_busy      <= 1'b0;
              o_valid     <= 1'b1;
              o_abort     <= 1'b0;
              o_sat       <= sat | w_max;
              o_delay_cnt <= dlat;
              o_width_cnt <= w_inc;
            end else begin
              wcnt <= w_inc;
              sat  <= sat | w_max;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_delay_timer_monitor.sv
// Randomized self-checking bench for delay_timer_monitor against an event-level model.
module tb_delay_timer_monitor;
  import delay_timer_pkg::*;

  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int W     = 2 + 2 * CNT_W;
`ifdef MONITOR_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             RESET = 1'b1;
  logic             i_en = 1'b0;
  logic             i_TRIG = 1'b0;
  logic             i_delay_n = 1'b1;
  logic [CNT_W-1:0] o_delay_cnt, o_width_cnt;
  logic             o_valid, o_sat, o_abort, o_busy;
  state_e           o_state;

  delay_timer_monitor #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .i_en        (i_en),
    .i_TRIG      (i_TRIG),
    .i_delay_n   (i_delay_n),
    .o_delay_cnt (o_delay_cnt),
    .o_width_cnt (o_width_cnt),
    .o_valid     (o_valid),
    .o_sat       (o_sat),
    .o_abort     (o_abort),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_exp = 0;
  int n_obs = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: results follow directly from the stimulus cycle counts.
  function automatic logic [W-1:0] model(input int d, input int w, input int tf, input bit abort);
    int dd, ww;
    bit s;
    dd = abort ? tf : d;
    ww = abort ? 0 : w;
    s  = (dd > MAXV) || (ww > MAXV);
    if (dd > MAXV) dd = MAXV;
    if (ww > MAXV) ww = MAXV;
    return {abort, s, dd[CNT_W-1:0], ww[CNT_W-1:0]};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (!RESET && o_valid) begin
      n_obs++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        logic [W-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", 32'({o_abort, o_sat, o_delay_cnt, o_width_cnt}), 32'(e));
        check("valid_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // driver: one event, trigger high for tf cycles, output asserted cycles [d, d+w)
  task automatic run_event(input int d, input int w, input int tf, input bit abort, input bit drop);
    int last, end_idx;
    end_idx = abort ? tf : d + w;
    last    = (abort || tf > d + w) ? tf : d + w;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      if (i == LAT) check("busy_active", 32'(o_busy), 32'd1);
      if (drop && i == 6) check("busy_after_drop", 32'(o_busy), 32'd0);
      i_TRIG    = (i < tf);
      i_delay_n = abort ? 1'b1 : !(i >= d && i < d + w);
      i_en      = drop ? !(i >= 3 && i < 5) : 1'b1;
      if (i == end_idx && !drop) begin
        exp_q.push_back(model(d, w, tf, abort));
        exp_cyc_q.push_back(cyc + LAT);
        n_exp++;
      end
    end
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      i_TRIG = 1'b0;
      i_delay_n = 1'b1;
      i_en = 1'b1;
    end
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    check("busy_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_delay"}, 32'(o_delay_cnt), 32'd0);
    check({tag, "_width"}, 32'(o_width_cnt), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_sat"},   32'(o_sat), 32'd0);
    check({tag, "_abort"}, 32'(o_abort), 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
  endtask

  initial begin
    int d, w, tf;
    bit ab;
    repeat (3) @(negedge clk);
    check_zero("reset");
    RESET = 1'b0;
    i_en  = 1'b1;
    repeat (3) @(negedge clk);

    run_event(0, 20, 20, 1'b0, 1'b0);    // OS-like
    run_event(5, 10, 10, 1'b0, 1'b0);    // DO-like
    run_event(0, 0, 4, 1'b1, 1'b0);      // abort
    run_event(300, 10, 305, 1'b0, 1'b0); // delay saturates
    run_event(3, 280, 3, 1'b0, 1'b0);    // width saturates, trig fall with out_on
    run_event(12, 8, 20, 1'b0, 1'b1);    // enable dropped in DELAY
    run_event(5, 10, 10, 1'b0, 1'b0);

    // reset in the middle of WIDTH
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      i_TRIG = 1'b1;
      i_delay_n = !(i >= 5);
    end
    #2 RESET = 1'b1;
    #1 check_zero("mid_reset");
    @(negedge clk);
    i_TRIG = 1'b0;
    i_delay_n = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    repeat (2) @(negedge clk);
    run_event(5, 10, 10, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ab = ($urandom_range(0, 4) == 0);
      d  = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 270) : $urandom_range(0, 40);
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 270) : $urandom_range(1, 30);
      if (ab) tf = $urandom_range(2, 40);
      else    tf = $urandom_range((d > 0) ? d : 1, d + w);
      run_event(d, w, tf, ab, 1'b0);
    end

    check("valid_count", 32'(n_obs), 32'(n_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
